iopad_in_filter: RTL
====================

# iopad_in_filter

Core-side conditioner for the digital input pad's pad-to-core signal (`p2c`). It synchronises the asynchronous `p2c` into the core clock domain and glitch-filters it with a programmable stable-count qualifier. It outputs a clean level, single-cycle edge strobes, and a one-entry edge-event buffer with a valid/ready handshake and a sticky overrun flag. It sits directly downstream of the input pad cell, one instance per pad.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth, ≥2.
- `CNT_W`, 8: width of the filter threshold and counter.
- `RST_LEVEL`, 1'b0: reset value of the synchroniser flops and of `level`.

- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `p2c` in 1: asynchronous pad-to-core input from the pad cell.
- `filt_len` in CNT_W: required number of consecutive differing samples. 0 is treated as 1.
- `level` out 1: filtered level.
- `rise` out 1: one-cycle strobe when `level` goes 0→1.
- `fall` out 1: one-cycle strobe when `level` goes 1→0.
- `evt_valid` out 1: event buffer holds an event.
- `evt_rise` out 1: buffered event type (1 = rise, 0 = fall).
- `evt_ready` in 1: consumer accepts the event.
- `ovf` out 1: sticky flag, set when an event was dropped.
- `ovf_clr` in 1: clears `ovf`.

## Operation
- Reset values:
  - synchroniser flops and `level`: `RST_LEVEL`.
  - `cnt`: 0; state: STABLE.
  - `rise`, `fall`, `evt_valid`, `evt_rise`, `ovf`: 0.
- Synchroniser: `SYNC_STAGES` flops in series; `sync_out` is the last stage. No logic between stages.
- Threshold: `thr = (filt_len == 0) ? 1 : filt_len`. `filt_len` is sampled every cycle and may change at any time.
- FSM:
  - STABLE: `sync_out == level`; `cnt` is held at 0.
  - STABLE → QUAL when `sync_out != level` and `thr > 1`; `cnt <= 1`.
  - STABLE with `sync_out != level` and `thr == 1`: `level` is updated immediately and the state stays STABLE.
  - QUAL, `sync_out == level` (glitch): → STABLE, `cnt <= 0`, no output change.
  - QUAL, `sync_out != level` and `cnt + 1 >= thr`: `level <= sync_out`, `cnt <= 0`, → STABLE.
  - QUAL, otherwise: `cnt <= cnt + 1`.
- `cnt` never wraps: it resets on acceptance. If `filt_len` is lowered below `cnt`, the next differing sample is accepted.
- `rise` and `fall` are registered and asserted in the same cycle that `level` takes its new value. They are mutually exclusive.
- Event buffer, evaluated on every `level` change:
  - Load when `!evt_valid || evt_ready`: `evt_valid <= 1`, `evt_rise <=` new level.
  - Otherwise the new event is dropped, the old event is kept, and `ovf <= 1`.
  - Without a new event, `evt_valid && evt_ready` clears `evt_valid`.
  - `evt_rise` is held while `evt_valid` is high.
- `ovf`: set has priority over a simultaneous `ovf_clr`; otherwise `ovf_clr` clears it.
- Reset asserted mid-qualification or mid-handshake: all state returns to reset values. Any pending event is lost and `ovf` is not set.

## Timing
- `p2c` change first sampled at edge N → `sync_out` changes after edge N+SYNC_STAGES-1 → `level`, `rise`/`fall` and the event load take effect after edge N+SYNC_STAGES+thr-1.
- Example: defaults with `filt_len` = 4 → `level` changes after edge N+5.
- Pulses narrower than `thr` synchronised cycles are fully suppressed.
- Minimum spacing between accepted edges is `thr` cycles.
- Handshake: an event transfers on any edge where `evt_valid && evt_ready`. A buffered event stays valid until accepted.
- Throughput: one event per cycle when `evt_ready` is held high.
- No combinational path from any input to any output.

## Structure
- Package `iopad_in_pkg`:
  - state enum `filt_state_t` {STABLE, QUAL};
  - `function thr_f(filt_len)` implementing the 0→1 mapping.
- Sub-module `iopad_in_sync` (parameters `SYNC_STAGES`, `RST_LEVEL`) holds the flop chain only. The FSM, counter and event buffer live in the top module.

## Test plan
- Reset with `p2c` = 1, `filt_len` = 4: `level` = 0 and all strobes 0 during reset. After release, `level` = 1 exactly 5 edges after the first sampling edge, with `rise` pulsed for exactly 1 cycle and `evt_valid` = 1, `evt_rise` = 1.
- `filt_len` = 4, `p2c` high pulses of 1, 2 and 3 cycles: `level` stays 0; no `rise`, no event, `ovf` = 0.
- `filt_len` = 0 vs 1: identical behaviour, `level` following `sync_out` one edge later. A 1-cycle glitch propagates.
- `evt_ready` = 0, `filt_len` = 1, toggle `p2c` every 4 cycles:
  - first event is kept (`evt_rise` = 1);
  - second toggle sets `ovf` = 1;
  - raising `evt_ready` drains one event and `evt_valid` drops.
  - Then `ovf_clr` clears `ovf`; `ovf_clr` in the same cycle as a new drop leaves `ovf` = 1.
- `evt_ready` held at 1, toggle `p2c` every `thr` cycles with `filt_len` = 2: every edge is delivered in order, `ovf` stays 0.
- Lower `filt_len` from 8 to 2 while `cnt` = 5 in QUAL: accept on the next differing sample. Assert `rst` mid-QUAL: `cnt` = 0, `level` = `RST_LEVEL`, `evt_valid` = 0 on the next cycle.

Source files
------------

// File: rtl/iopad_in_pkg.sv
// Shared types and helpers for the pad input conditioner.
package iopad_in_pkg;

    // Filter state: STABLE while the synchronised input matches the level,
    // QUAL while a differing value is being counted.
    typedef enum logic [0:0] {
        STABLE = 1'b0,
        QUAL   = 1'b1
    } filt_state_t;

    // Effective stable-count threshold: a programmed 0 behaves like 1.
    function automatic int unsigned thr_f(input int unsigned filt_len);
        return (filt_len == 0) ? 32'd1 : filt_len;
    endfunction

endpackage

// File: rtl/iopad_in_filter_if.sv
// Core-side bus of the pad input conditioner. The master drives the pad
// input and the controls; the slave (the filter) drives level, strobes,
// the event buffer and debug visibility of the filter state.
//
// Event handshake: evt_valid/evt_rise are registered outputs. An event
// transfers on every rising clk edge where evt_valid && evt_ready. Once
// evt_valid is high it and evt_rise stay unchanged until that transfer.
// evt_ready may be driven freely and never depends on evt_valid.
interface iopad_in_filter_if #(
    parameter int CNT_W = 8
);
    logic                      p2c;
    logic [CNT_W-1:0]          filt_len;
    logic                      level;
    logic                      rise;
    logic                      fall;
    logic                      evt_valid;
    logic                      evt_rise;
    logic                      evt_ready;
    logic                      ovf;
    logic                      ovf_clr;
    iopad_in_pkg::filt_state_t dbg_state;
    logic [CNT_W-1:0]          dbg_cnt;

    modport master (
        output p2c, filt_len, evt_ready, ovf_clr,
        input  level, rise, fall, evt_valid, evt_rise, ovf, dbg_state, dbg_cnt
    );

    modport slave (
        input  p2c, filt_len, evt_ready, ovf_clr,
        output level, rise, fall, evt_valid, evt_rise, ovf, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/iopad_in_sync.sv
// Plain flop-chain synchroniser for the asynchronous pad input.
module iopad_in_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input through the chain; no logic between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/iopad_in_filter.sv
// Pad input conditioner: synchronise p2c, qualify each change with a
// programmable stable count, publish the clean level, edge strobes and a
// one-entry edge-event buffer with a sticky overrun flag.
module iopad_in_filter
    import iopad_in_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 8,
    parameter logic RST_LEVEL   = 1'b0
) (
    input logic               clk,
    input logic               rst,
    iopad_in_filter_if.slave  bus
);
    logic             sync_out;
    logic [CNT_W:0]   thr;
    logic [CNT_W:0]   cnt_inc;
    logic             diff;
    logic             accept;
    logic             ovf_set;

    filt_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_rise_q, evt_rise_d;
    logic             ovf_q, ovf_d;

    iopad_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_LEVEL   (RST_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.p2c),
        .q_o (sync_out)
    );

    // One extra bit so cnt + 1 never wraps before it is compared.
    assign thr     = (CNT_W+1)'(thr_f(32'(bus.filt_len)));
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign diff    = (sync_out != level_q);

    // Qualifier: count consecutive differing samples, accept at threshold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (diff) begin
                    if (thr == (CNT_W+1)'(1)) begin
                        accept = 1'b1;
                    end else begin
                        state_d = QUAL;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            QUAL: begin
                if (!diff) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_inc >= thr) begin
                    accept  = 1'b1;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Level, strobes, event buffer and overrun flag driven by an accept.
    always_comb begin
        level_d     = level_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        evt_valid_d = evt_valid_q;
        evt_rise_d  = evt_rise_q;
        ovf_set     = 1'b0;
        if (accept) begin
            level_d = sync_out;
            rise_d  = sync_out;
            fall_d  = !sync_out;
            if (!evt_valid_q || bus.evt_ready) begin
                evt_valid_d = 1'b1;
                evt_rise_d  = sync_out;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (evt_valid_q && bus.evt_ready) begin
            evt_valid_d = 1'b0;
        end
        // A new drop wins over a simultaneous clear request.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers; reset discards any pending event without flagging it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STABLE;
            cnt_q       <= '0;
            level_q     <= RST_LEVEL;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_rise_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            evt_valid_q <= evt_valid_d;
            evt_rise_q  <= evt_rise_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.level     = level_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_rise  = evt_rise_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_cnt   = cnt_q;
endmodule
